// File: rtl/requant_pkg.sv
// Shared types and constants for the requantize / ReLU / INT8 saturation stage.
package requant_pkg;

  typedef struct packed {
    logic signed [31:0] bias;
    logic        [15:0] mult;
    logic        [4:0]  shift;
  } ch_param_t;

  // Identity entry: result is the accumulator itself, then clamped to INT8.
  localparam ch_param_t CH_PARAM_RESET = '{bias: 32'sd0, mult: 16'd1, shift: 5'd0};

  localparam logic signed [7:0] INT8_MAX = 8'sh7F;
  localparam logic signed [7:0] INT8_MIN = 8'sh80;

  typedef logic signed [49:0] prod_t;

endpackage

// File: rtl/requant_param_table.sv
// Per-channel requant parameter table: synchronous write, combinational read.
// Out-of-range writes are dropped; out-of-range reads return the reset entry.
module requant_param_table
  import requant_pkg::*;
#(
  parameter int NUM_CH = 32,
  parameter int CH_W   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [CH_W-1:0] i_wr_addr,
  input  ch_param_t       i_wr_dat,
  input  logic [CH_W-1:0] i_rd_addr,
  output ch_param_t       o_rd_dat
);

  localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  ch_param_t r_tab [NUM_CH];
  logic      w_wr_ok;
  logic      w_rd_ok;

  assign w_wr_ok = ({1'b0, i_wr_addr} < (CH_W+1)'(NUM_CH));
  assign w_rd_ok = ({1'b0, i_rd_addr} < (CH_W+1)'(NUM_CH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tab <= '{default: CH_PARAM_RESET};
    end else if (i_we && w_wr_ok) begin
      r_tab[AW'(i_wr_addr)] <= i_wr_dat;
    end
  end

  assign o_rd_dat = w_rd_ok ? r_tab[AW'(i_rd_addr)] : CH_PARAM_RESET;

endmodule

// File: rtl/requant_relu.sv
// Bias add, scale multiply, rounding shift, optional ReLU, INT8 clamp; 3-cycle latency, 1 beat/cycle.
// Any held output stalls the whole pipe (in_ready = !stall). REQUANT_SAT_STATS_EN builds the saturation counter.
module requant_relu
  import requant_pkg::*;
#(
  parameter int NUM_CH = 32,
  parameter int CH_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_acc,
  input  logic [CH_W-1:0]    in_ch,
  input  logic               in_last,
  input  logic               relu_en,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_addr,
  input  logic signed [31:0] cfg_bias,
  input  logic [15:0]        cfg_mult,
  input  logic [4:0]         cfg_shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [7:0]  out_data,
  output logic               out_last,
  output logic [15:0]        sat_count
);

  ch_param_t w_cfg;
  ch_param_t w_prm;
  logic      w_stall;

  assign w_cfg    = '{bias: cfg_bias, mult: cfg_mult, shift: cfg_shift};
  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;

  requant_param_table #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_param_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (cfg_we),
    .i_wr_addr (cfg_addr),
    .i_wr_dat  (w_cfg),
    .i_rd_addr (in_ch),
    .o_rd_dat  (w_prm)
  );

  // S1: bias add at full 33-bit width so it can never wrap.
  logic signed [32:0] w_sum;
  assign w_sum = {in_acc[31], in_acc} + {w_prm.bias[31], w_prm.bias};

  logic               r_v1, r_last1, r_relu1;
  logic signed [32:0] r_sum1;
  logic [15:0]        r_mult1;
  logic [4:0]         r_shift1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_last1  <= 1'b0;
      r_relu1  <= 1'b0;
      r_sum1   <= '0;
      r_mult1  <= '0;
      r_shift1 <= '0;
    end else if (!w_stall) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_last1  <= in_last;
        r_relu1  <= relu_en;
        r_sum1   <= w_sum;
        r_mult1  <= w_prm.mult;
        r_shift1 <= w_prm.shift;
      end
    end
  end

  // S2: signed 33 x unsigned 16 multiply.
  logic        r_v2, r_last2, r_relu2;
  prod_t       r_prod2;
  logic [4:0]  r_shift2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2     <= 1'b0;
      r_last2  <= 1'b0;
      r_relu2  <= 1'b0;
      r_prod2  <= '0;
      r_shift2 <= '0;
    end else if (!w_stall) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_last2  <= r_last1;
        r_relu2  <= r_relu1;
        r_prod2  <= prod_t'(r_sum1) * prod_t'($signed({1'b0, r_mult1}));
        r_shift2 <= r_shift1;
      end
    end
  end

  // S3: round half toward +inf, ReLU, clamp.
  prod_t            w_rnd;
  prod_t            w_shr;
  prod_t            w_r;
  logic             w_hi, w_lo;
  logic signed [7:0] w_q;

  always_comb begin
    w_rnd = '0;
    if (r_shift2 != 5'd0) w_rnd = 50'sd1 <<< (r_shift2 - 5'd1);
    w_shr = (r_prod2 + w_rnd) >>> r_shift2;
    w_r   = (r_relu2 && w_shr[49]) ? '0 : w_shr;
    w_hi  = (w_r > prod_t'(INT8_MAX));
    w_lo  = (w_r < prod_t'(INT8_MIN));
    w_q   = w_hi ? INT8_MAX : (w_lo ? INT8_MIN : w_r[7:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (!w_stall) begin
      out_valid <= r_v2;
      if (r_v2) begin
        out_data <= w_q;
        out_last <= r_last2;
      end
    end
  end

`ifdef REQUANT_SAT_STATS_EN
  logic [15:0] r_sat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt <= '0;
    end else if (!w_stall && r_v2 && (w_hi || w_lo) && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign sat_count = r_sat_cnt;
`else
  assign sat_count = '0;
`endif

endmodule

// File: doc/requant_relu.md
Name: requant_relu

Overview:
- Downstream of the INT8 MAC array: consumes finished 32-bit signed accumulator results and produces signed INT8 activations for the next layer.
- Per-output-channel bias add, fixed-point scale multiply, rounding right shift, optional ReLU, saturation to INT8.
- 3-stage pipeline with valid/ready handshake on both sides.
- Per-channel parameters come from a small register table written by the layer controller.

Parameters:
- NUM_CH, 32, number of output channels held in the parameter table
- CH_W, 5, channel index width; must satisfy 2^CH_W >= NUM_CH

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  accumulator beat valid
- in_ready  out  1  block can accept a beat
- in_acc  in  32  signed accumulator value
- in_ch  in  CH_W  output-channel index of the beat
- in_last  in  1  last beat of tile, passed through
- relu_en  in  1  global ReLU enable, sampled with each beat at S1
- cfg_we  in  1  parameter table write strobe
- cfg_addr  in  CH_W  table entry to write
- cfg_bias  in  32  signed bias
- cfg_mult  in  16  unsigned scale multiplier
- cfg_shift  in  5  right-shift amount, 0..31
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  8  signed INT8 result
- out_last  out  1  in_last delayed with its beat
- sat_count  out  16  saturation event counter (see Optional Feature)

Behaviour:
- Reset (async): all pipeline valid bits 0; out_valid=0, out_data=0, out_last=0, sat_count=0.
- Reset: every table entry becomes bias=0, mult=1, shift=0, i.e. identity then saturate.
- Handshake: input fires on in_valid&&in_ready; output fires on out_valid&&out_ready.
  - out_valid/out_data/out_last hold stable while out_valid&&!out_ready.
  - Global stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - A stall freezes all stages. Bubbles are not compressed while stalled.
- Latency: exactly 3 cycles from input fire to out_valid with no stall. Throughput is 1 beat/cycle.
- S1 (capture): register in_acc, in_last, relu_en, and the table entry for in_ch.
  - Compute sum = in_acc + bias as 33-bit signed (no wrap).
- S2 (multiply): prod = sum × {1'b0, mult} as 50-bit signed. Maps to one DSP.
- S3 (round/shift/clamp):
  - If shift>0: r = (prod + 2^(shift-1)) >>> shift (round half toward +inf). If shift=0: r = prod.
  - If relu_en and r<0: r = 0.
  - Saturate r to [-128, 127], register to out_data.
  - A saturation event is r>127 or r<-128 after ReLU.
- Table writes:
  - A write takes effect the cycle after cfg_we.
  - A beat captured in the same cycle as a write to its channel uses the old entry.
  - cfg_addr >= NUM_CH: write ignored.
  - in_ch >= NUM_CH: beat uses the reset entry (bias 0, mult 1, shift 0).
  - Writes are accepted during a stall.
- Beat order and in_last are preserved exactly. No beat is dropped or duplicated.
- rst_n asserted mid-stream: in-flight beats are discarded, out_valid drops immediately, table returns to reset values.

Optional Feature:
- Macro: REQUANT_SAT_STATS_EN.
- Defined: sat_count increments by 1 on each saturation event at S3 register load. It sticks at 16'hFFFF and clears only on reset.
- Undefined: counter logic is not built; sat_count is tied to 0.
- Datapath output is identical either way.

Decomposition:
- Shared package requant_pkg holds:
  - struct ch_param_t {bias[31:0], mult[15:0], shift[4:0]}
  - constant CH_PARAM_RESET
  - constants INT8_MAX=127 and INT8_MIN=-128
  - typedef for the 50-bit product
- One natural sub-module: requant_param_table. Synchronous write, combinational read, NUM_CH entries, reset to CH_PARAM_RESET.

Test Plan:
- Reset defaults, in_acc=100, ch=0, relu_en=0, out_ready=1 -> out_data=100 exactly 3 cycles after fire.
- ch3 = {bias=-50, mult=3, shift=2}, in_acc=20 -> (-30×3=-90, +2)>>>2 = -22. Same beat with relu_en=1 -> 0.
- Reset defaults, in_acc=1000 -> 127; in_acc=-1000 -> -128. With REQUANT_SAT_STATS_EN, sat_count=2.
- Rounding, ch1 = {0, 1, 1}: in_acc=3 -> 2, in_acc=-3 -> -1, in_acc=5 -> 3.
- Stream 10 beats (in_last on 10th), out_ready toggling 1,0,0,1 pattern -> 10 outputs in order, values held during stalls, out_last only on 10th.
- Write ch2 mult=2 in the same cycle a ch2 beat (acc=10) fires -> 10; next ch2 beat -> 20. cfg_addr=40 write has no effect. Reset mid-stream -> out_valid=0 next edge.
